// File: rtl/tsens_decim.sv
// Temperature-sensor incremental-ADC decimator: counts comparator decisions over an OSR-strobe window.
// Latency: code/code_valid update on the edge that samples the OSR-th strobe of a window.
// Backpressure: none upstream; an unaccepted code is overwritten by the next window and flags sticky overrun.
//
// Ports: clk/reset (async, active-high); en, bit_stb, bit_in from the sequencer;
//        code/code_valid/code_ready handshake to the readout block; busy, overrun, sat status.
// Optional: define TSENS_DECIM_SINC2_EN for a second integrator (sinc2 weighting); default is a plain ones count.
module tsens_decim #(
    parameter int OSR     = 256,
    parameter int DISCARD = 2,
    parameter int CODE_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              bit_stb,
    input  logic              bit_in,
    input  logic              code_ready,
    output logic [CODE_W-1:0] code,
    output logic              code_valid,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd1;
    localparam logic [1:0] S_ACCUM   = 2'd2;

    localparam int ACC1_W = $clog2(OSR + 1);
`ifdef TSENS_DECIM_SINC2_EN
    localparam int SUM_MAX = OSR * (OSR + 1) / 2;
`else
    localparam int SUM_MAX = OSR;
`endif
    localparam int SUM_W  = $clog2(SUM_MAX + 1);
    localparam int CMP_W  = (SUM_W > CODE_W) ? SUM_W : CODE_W;
    localparam int CNT_W  = $clog2(OSR);
    localparam int DCNT_W = (DISCARD > 1) ? $clog2(DISCARD) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(OSR - 1);
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'((DISCARD > 0) ? DISCARD - 1 : 0);

    logic [1:0]        state;
    logic [ACC1_W-1:0] acc1;
    logic [ACC1_W-1:0] acc1_nxt;
    logic [CNT_W-1:0]  bcnt;
    logic [DCNT_W-1:0] dcnt;
    logic [SUM_W-1:0]  sum;
    logic [CMP_W-1:0]  sum_ext;
    logic [CMP_W-1:0]  max_ext;
    logic              sat_now;
    logic [CODE_W-1:0] code_nxt;
    logic              close;
    logic              transfer;

    // Sums include the bit sampled on the current edge so the closing strobe counts.
    assign acc1_nxt = acc1 + ACC1_W'(bit_in);

`ifdef TSENS_DECIM_SINC2_EN
    logic [SUM_W-1:0] acc2;
    logic [SUM_W-1:0] acc2_nxt;

    assign acc2_nxt = acc2 + SUM_W'(acc1_nxt);
    assign sum      = acc2_nxt;
`else
    assign sum      = SUM_W'(acc1_nxt);
`endif

    assign sum_ext  = CMP_W'(sum);
    assign max_ext  = CMP_W'({CODE_W{1'b1}});
    assign sat_now  = (sum_ext > max_ext);
    assign code_nxt = sat_now ? {CODE_W{1'b1}} : CODE_W'(sum);

    assign close    = en && bit_stb && (state == S_ACCUM) && (bcnt == CNT_LAST);
    assign transfer = code_valid && code_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            acc1       <= '0;
`ifdef TSENS_DECIM_SINC2_EN
            acc2       <= '0;
`endif
            bcnt       <= '0;
            dcnt       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            busy       <= 1'b0;
            overrun    <= 1'b0;
            sat        <= 1'b0;
        end else begin
            // Any enabled edge leaves or stays out of IDLE, so busy simply tracks en one edge later.
            busy <= en;

            if (transfer) begin
                code_valid <= 1'b0;
            end

            if (!en) begin
                // Partial window is dropped; a pending code stays available for the consumer.
                state   <= S_IDLE;
                acc1    <= '0;
`ifdef TSENS_DECIM_SINC2_EN
                acc2    <= '0;
`endif
                bcnt    <= '0;
                dcnt    <= '0;
                overrun <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= (DISCARD > 0) ? S_DISCARD : S_ACCUM;
                        dcnt  <= '0;
                    end
                    S_DISCARD: begin
                        if (bit_stb) begin
                            if (dcnt == DCNT_LAST) begin
                                state <= S_ACCUM;
                                dcnt  <= '0;
                            end else begin
                                dcnt <= dcnt + DCNT_W'(1);
                            end
                        end
                    end
                    S_ACCUM: begin
                        if (close) begin
                            code       <= code_nxt;
                            code_valid <= 1'b1;
                            sat        <= sat_now;
                            if (code_valid && !code_ready) begin
                                overrun <= 1'b1;
                            end
                            acc1 <= '0;
`ifdef TSENS_DECIM_SINC2_EN
                            acc2 <= '0;
`endif
                            bcnt <= '0;
                        end else if (bit_stb) begin
                            acc1 <= acc1_nxt;
`ifdef TSENS_DECIM_SINC2_EN
                            acc2 <= acc2_nxt;
`endif
                            bcnt <= bcnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tsens_decim.sv
// Self-checking bench for tsens_decim: two instances (OSR=8 with DISCARD=2/CODE_W=16, and DISCARD=0/CODE_W=3).
// Expected codes come from a weighted bit-sum model over each window, clipped to the code width.
// Define TSENS_DECIM_SINC2_EN for both bench and RTL to exercise the sinc2 build.
module tb_tsens_decim;

    localparam int OSR = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic en_v  [2];
    logic stb_v [2];
    logic bin_v [2];
    logic rdy_v [2];

    logic [15:0] code_a;
    logic        vld_a, busy_a, ovr_a, sat_a;
    logic [2:0]  code_b;
    logic        vld_b, busy_b, ovr_b, sat_b;

    int checks = 0;
    int errors = 0;

    tsens_decim #(.OSR(OSR), .DISCARD(2), .CODE_W(16)) dut_a (
        .clk(clk), .reset(reset), .en(en_v[0]), .bit_stb(stb_v[0]), .bit_in(bin_v[0]),
        .code_ready(rdy_v[0]), .code(code_a), .code_valid(vld_a), .busy(busy_a),
        .overrun(ovr_a), .sat(sat_a)
    );

    tsens_decim #(.OSR(OSR), .DISCARD(0), .CODE_W(3)) dut_b (
        .clk(clk), .reset(reset), .en(en_v[1]), .bit_stb(stb_v[1]), .bit_in(bin_v[1]),
        .code_ready(rdy_v[1]), .code(code_b), .code_valid(vld_b), .busy(busy_b),
        .overrun(ovr_b), .sat(sat_b)
    );

    function automatic logic [15:0] get_code(input int sel);
        return (sel == 0) ? code_a : {13'b0, code_b};
    endfunction
    function automatic logic get_vld(input int sel);
        return (sel == 0) ? vld_a : vld_b;
    endfunction
    function automatic logic get_sat(input int sel);
        return (sel == 0) ? sat_a : sat_b;
    endfunction
    function automatic logic get_ovr(input int sel);
        return (sel == 0) ? ovr_a : ovr_b;
    endfunction
    function automatic logic get_busy(input int sel);
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    // Bit i is the i-th accumulated strobe of the window. sinc1 counts ones;
    // sinc2 weights the i-th bit by the number of integrations it survives (OSR - i).
    function automatic int raw_sum(input logic [7:0] bits);
        int s = 0;
        for (int i = 0; i < OSR; i++) begin
`ifdef TSENS_DECIM_SINC2_EN
            if (bits[i]) s += OSR - i;
`else
            if (bits[i]) s += 1;
`endif
        end
        return s;
    endfunction

    function automatic int max_code(input int sel);
        return (sel == 0) ? 65535 : 7;
    endfunction

    // Called at a negedge; drives one strobe and returns at the following negedge.
    task automatic strobe(input int sel, input logic b);
        stb_v[sel] = 1'b1;
        bin_v[sel] = b;
        @(negedge clk);
        stb_v[sel] = 1'b0;
        bin_v[sel] = 1'b0;
    endtask

    task automatic discard_phase(input int sel);
        for (int i = 0; i < 2; i++) strobe(sel, 1'b1);
    endtask

    task automatic run_window(input int sel, input logic [7:0] bits, input bit gaps, input string name);
        int raw;
        int exp_code;
        bit exp_sat;
        for (int i = 0; i < OSR; i++) begin
            strobe(sel, bits[i]);
            if (gaps && i < OSR - 1) repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        raw      = raw_sum(bits);
        exp_code = (raw > max_code(sel)) ? max_code(sel) : raw;
        exp_sat  = (raw > max_code(sel));
        checks++;
        if (get_code(sel) !== 16'(exp_code)) begin
            errors++;
            $display("FAIL %s code: got %0d expected %0d (bits %b)", name, get_code(sel), exp_code, bits);
        end
        checks++;
        if (get_vld(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s valid: got %b expected 1", name, get_vld(sel));
        end
        checks++;
        if (get_sat(sel) !== exp_sat) begin
            errors++;
            $display("FAIL %s sat: got %b expected %b", name, get_sat(sel), exp_sat);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            checks++;
            if (get_code(s) !== 16'd0 || get_vld(s) !== 1'b0 || get_busy(s) !== 1'b0 ||
                get_ovr(s) !== 1'b0 || get_sat(s) !== 1'b0) begin
                errors++;
                $display("FAIL reset dut%0d: code=%0d vld=%b busy=%b ovr=%b sat=%b expected all 0",
                         s, get_code(s), get_vld(s), get_busy(s), get_ovr(s), get_sat(s));
            end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    // DISCARD=0 instance: all-ones saturates the 3-bit code, then random back-to-back windows.
    task automatic test_no_discard_sat();
        rdy_v[1] = 1'b1;
        en_v[1]  = 1'b1;
        @(negedge clk);
        run_window(1, 8'hFF, 1'b0, "b_all_ones");
        @(negedge clk);
        checks++;
        if (vld_b !== 1'b0) begin
            errors++;
            $display("FAIL b_valid_drop: got %b expected 0", vld_b);
        end
        for (int w = 0; w < 4; w++) begin
            run_window(1, 8'($urandom_range(0, 255)), 1'b0, "b_back_to_back");
        end
        run_window(1, 8'h00, 1'b1, "b_all_zeros");
        checks++;
        if (ovr_b !== 1'b0) begin
            errors++;
            $display("FAIL b_no_overrun: got %b expected 0", ovr_b);
        end
        en_v[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_discard();
        rdy_v[0] = 1'b1;
        en_v[0]  = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL a_busy_on: got %b expected 1", busy_a);
        end
        discard_phase(0);
        run_window(0, 8'h55, 1'b0, "a_alternating");
        @(negedge clk);
        checks++;
        if (vld_a !== 1'b0) begin
            errors++;
            $display("FAIL a_valid_pulse: got %b expected 0", vld_a);
        end
        run_window(0, 8'h00, 1'b0, "a_all_zeros");
        for (int w = 0; w < 3; w++) begin
            run_window(0, 8'($urandom_range(0, 255)), 1'b1, "a_random");
        end
    endtask

    task automatic test_overrun();
        logic [7:0] bits_a;
        logic [7:0] bits_b;
        int exp_a;
        int exp_b;
        bits_a = 8'b1011_0101;
        bits_b = 8'b0100_1010;
        exp_a  = raw_sum(bits_a);
        exp_b  = raw_sum(bits_b);
        @(negedge clk);
        rdy_v[0] = 1'b0;
        run_window(0, bits_a, 1'b0, "ovr_first");
        for (int i = 0; i < 4; i++) strobe(0, bits_b[i]);
        checks++;
        if (code_a !== 16'(exp_a) || vld_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_code_stable: got code=%0d vld=%b expected code=%0d vld=1", code_a, vld_a, exp_a);
        end
        for (int i = 4; i < OSR; i++) strobe(0, bits_b[i]);
        checks++;
        if (code_a !== 16'(exp_b) || vld_a !== 1'b1 || ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_second: got code=%0d vld=%b ovr=%b expected code=%0d vld=1 ovr=1",
                     code_a, vld_a, ovr_a, exp_b);
        end
        rdy_v[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (vld_a !== 1'b0 || ovr_a !== 1'b1) begin
            errors++;
            $display("FAIL ovr_accept: got vld=%b ovr=%b expected vld=0 ovr=1", vld_a, ovr_a);
        end
        en_v[0] = 1'b0;
        @(negedge clk);
        checks++;
        if (ovr_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL ovr_idle_clear: got ovr=%b busy=%b expected 0 0", ovr_a, busy_a);
        end
    endtask

    task automatic test_partial_window();
        en_v[0] = 1'b1;
        @(negedge clk);
        discard_phase(0);
        for (int i = 0; i < 5; i++) strobe(0, 1'b1);
        en_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (vld_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL partial_no_code: got vld=%b busy=%b expected 0 0", vld_a, busy_a);
        end
        en_v[0] = 1'b1;
        @(negedge clk);
        discard_phase(0);
        run_window(0, 8'hFF, 1'b0, "partial_reenable");
    endtask

    task automatic test_reset_mid_window();
        @(negedge clk);
        rdy_v[0] = 1'b0;
        run_window(0, 8'($urandom_range(0, 255)), 1'b0, "pre_reset");
        for (int i = 0; i < 3; i++) strobe(0, 1'b1);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (code_a !== 16'd0 || vld_a !== 1'b0 || busy_a !== 1'b0 || ovr_a !== 1'b0 || sat_a !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: code=%0d vld=%b busy=%b ovr=%b sat=%b expected all 0",
                     code_a, vld_a, busy_a, ovr_a, sat_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        discard_phase(0);
        run_window(0, 8'($urandom_range(0, 255)), 1'b1, "post_reset");
        checks++;
        if (ovr_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_overrun: got %b expected 0", ovr_a);
        end
    endtask

    initial begin
        reset = 1'b1;
        for (int s = 0; s < 2; s++) begin
            en_v[s]  = 1'b0;
            stb_v[s] = 1'b0;
            bin_v[s] = 1'b0;
            rdy_v[s] = 1'b0;
        end
        test_reset();
        test_no_discard_sat();
        test_discard();
        test_overrun();
        test_partial_window();
        test_reset_mid_window();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
